conf_reg_bank: RTL and testbench
================================

Name: conf_reg_bank

Overview:
- Downstream consumer of the CONF write stream (c_addr/c_data/c_valid, backpressured by c_ready).
- Holds a shadow register set written by the stream, and an active register set driven to the datapath.
- A write to the commit address runs a multi-cycle copy from shadow to active, then signals the update.
- Provides a combinational read-back port for active registers.

Parameters:
- NUM_REGS, 15, number of shadow/active registers (must be ≤ 2**ADDR_W - 1).
- ADDR_W, 4, width of c_addr.
- DATA_W, 14, width of c_data and of each register.
- COMMIT_ADDR, 15, control address; must be ≥ NUM_REGS.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- c_valid  input  1  write request valid.
- c_addr  input  ADDR_W  register address.
- c_data  input  DATA_W  write data.
- c_ready  output  1  bank can accept a write (registered).
- cfg_regs  output  NUM_REGS*DATA_W  active registers flattened; reg i at [i*DATA_W +: DATA_W].
- cfg_update  output  1  one-cycle pulse when a commit completes.
- err_addr  output  1  one-cycle pulse on an accepted write to an unmapped address.
- rd_addr  input  ADDR_W  read-back address.
- rd_data  output  DATA_W  active[rd_addr]; 0 if rd_addr ≥ NUM_REGS (combinational).

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset values:
  - shadow, active: all 0.
  - c_ready, cfg_update, err_addr: 0.
  - FSM: IDLE; copy index: 0.
- c_ready rises on the first edge with rst low.
- Transfer occurs at a posedge where c_valid && c_ready. No transfer when c_ready = 0; the producer must hold its data.
- FSM state IDLE (c_ready = 1):
  - addr < NUM_REGS: shadow[addr] <= data.
  - addr == COMMIT_ADDR:
    - data[1] = 1: clear all shadow registers to 0.
    - data[0] = 1: go to COMMIT with idx = 0 and drive c_ready <= 0 on the same edge.
    - Both bits set: clear first, then commit (the committed values are zeros).
    - data[0] = 0: stay in IDLE.
  - Any other address: write dropped, err_addr pulses in the next cycle.
- FSM state COMMIT (c_ready = 0):
  - Each cycle: active[idx] <= shadow[idx], idx++.
  - After idx == NUM_REGS-1: go to DONE.
- FSM state DONE (c_ready = 0): cfg_update = 1 for exactly this cycle; c_ready <= 1; go to IDLE.
- Timing: commit accepted at the edge ending cycle N.
  - c_ready is low for cycles N+1 .. N+NUM_REGS+1.
  - cfg_update is high in cycle N+NUM_REGS+1.
  - Active registers are fully updated from cycle N+NUM_REGS+1.
  - c_ready is high again in cycle N+NUM_REGS+2.
- Active registers change only in COMMIT. Shadow writes never show on cfg_regs until a commit.
- Reset mid-COMMIT aborts the copy: all registers go to 0, no cfg_update.
- idx width is clog2(NUM_REGS). No wrap beyond NUM_REGS-1.

Optional Feature:
- Macro: CONF_WRCNT_EN.
- Defined:
  - Adds output wr_count (16 bits): number of accepted transfers, all addresses included.
  - Saturates at 16'hFFFF; resets to 0.
  - Increments on the cycle after acceptance.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (conf_pack) holds:
  - CONF_ADDR_W = 4, CONF_DATA_W = 14, COMMIT_ADDR = 15.
  - Commit-bit positions: CMD_COMMIT = 0, CMD_CLEAR = 1.
  - FSM enum conf_state_t {IDLE, COMMIT, DONE}.
- No sub-module; single module with the FSM inline.

Test Plan:
- Reset, then idle: after rst falls, c_ready = 1 next cycle; all cfg_regs = 0, rd_data = 0.
- Write addr 3 = 14'h1ABC with no commit: cfg_regs[3] stays 0. Then commit (addr 15, data 1): c_ready low 16 cycles, cfg_update pulses once, rd_addr = 3 gives 14'h1ABC.
- Hold c_valid high during COMMIT with addr 5 = 14'h0055: nothing accepted until c_ready returns; then the write lands in shadow[5], and active[5] stays unchanged.
- Write addr 15, data 3 after loading shadow: all active registers become 0 after 16 cycles, cfg_update = 1.
- Assert rst at COMMIT idx = 7: all registers 0, cfg_update never pulses, c_ready = 1 the cycle after rst falls.
- Write to addr 15 with data 0: no state change, no err_addr. (Unmapped-address writes to NUM_REGS..14 exist only when NUM_REGS < 15; with NUM_REGS = 12, a write to addr 13 gives an err_addr pulse and shadow unchanged.)

Source files
------------

// File: rtl/conf_pack.sv
// rtl/conf_pack.sv - shared constants, command bits and FSM states for the CONF register bank
package conf_pack;

  localparam int CONF_ADDR_W = 4;
  localparam int CONF_DATA_W = 14;
  localparam int COMMIT_ADDR = 15;

  localparam int CMD_COMMIT = 0;
  localparam int CMD_CLEAR  = 1;

  typedef enum logic [1:0] {
    IDLE,
    COMMIT,
    DONE
  } conf_state_t;

endpackage

// File: rtl/conf_reg_bank.sv
// rtl/conf_reg_bank.sv - shadow/active CONF register bank with multi-cycle commit copy
// Optional wr_count output is built when CONF_WRCNT_EN is defined.
module conf_reg_bank #(
  parameter int NUM_REGS    = 15,
  parameter int ADDR_W      = conf_pack::CONF_ADDR_W,
  parameter int DATA_W      = conf_pack::CONF_DATA_W,
  parameter int COMMIT_ADDR = conf_pack::COMMIT_ADDR
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       c_valid,
  input  logic [ADDR_W-1:0]          c_addr,
  input  logic [DATA_W-1:0]          c_data,
  output logic                       c_ready,
  output logic [NUM_REGS*DATA_W-1:0] cfg_regs,
  output logic                       cfg_update,
  output logic                       err_addr,
`ifdef CONF_WRCNT_EN
  output logic [15:0]                wr_count,
`endif
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic [DATA_W-1:0]          rd_data
);
  import conf_pack::*;

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W-1:0] NUM_A    = ADDR_W'(NUM_REGS);
  localparam logic [ADDR_W-1:0] COMMIT_A = ADDR_W'(COMMIT_ADDR);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_REGS - 1);

  conf_state_t       state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shadow_q [NUM_REGS];
  logic [DATA_W-1:0] shadow_d [NUM_REGS];
  logic [DATA_W-1:0] active_q [NUM_REGS];
  logic [DATA_W-1:0] active_d [NUM_REGS];
  logic              c_ready_q, c_ready_d;
  logic              cfg_update_q, cfg_update_d;
  logic              err_addr_q, err_addr_d;
  logic              accept;

  always_comb begin
    accept       = c_valid && c_ready_q;
    state_d      = state_q;
    idx_d        = idx_q;
    shadow_d     = shadow_q;
    active_d     = active_q;
    cfg_update_d = 1'b0;
    err_addr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (c_addr < NUM_A) begin
            shadow_d[c_addr] = c_data;
          end else if (c_addr == COMMIT_A) begin
            // Clear is applied before the commit starts, so clear+commit publishes zeros.
            if (c_data[CMD_CLEAR]) begin
              for (int i = 0; i < NUM_REGS; i++) shadow_d[i] = '0;
            end
            if (c_data[CMD_COMMIT]) begin
              state_d = COMMIT;
              idx_d   = '0;
            end
          end else begin
            err_addr_d = 1'b1;
          end
        end
      end
      COMMIT: begin
        active_d[idx_q] = shadow_q[idx_q];
        if (idx_q == LAST_IDX) begin
          state_d      = DONE;
          cfg_update_d = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    c_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      c_ready_q    <= 1'b0;
      cfg_update_q <= 1'b0;
      err_addr_q   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      c_ready_q    <= c_ready_d;
      cfg_update_q <= cfg_update_d;
      err_addr_q   <= err_addr_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
    end
  end

`ifdef CONF_WRCNT_EN
  logic [15:0] wr_count_q, wr_count_d;

  always_comb begin
    wr_count_d = wr_count_q;
    if (accept && (wr_count_q != 16'hFFFF)) wr_count_d = wr_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) wr_count_q <= '0;
    else     wr_count_q <= wr_count_d;
  end

  assign wr_count = wr_count_q;
`endif

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == ADDR_W'(i)) rd_data = active_q[i];
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign cfg_regs[g*DATA_W +: DATA_W] = active_q[g];
  end

  assign c_ready    = c_ready_q;
  assign cfg_update = cfg_update_q;
  assign err_addr   = err_addr_q;

endmodule

// File: tb/tb_conf_reg_bank.sv
// tb/tb_conf_reg_bank.sv - randomized directed bench for conf_reg_bank against a shadow/active model
module tb_conf_reg_bank;
  localparam int NR  = 15;
  localparam int NR2 = 12;
  localparam int DW  = 14;
  localparam int CW  = NR * DW;

  logic              clk = 1'b0;
  logic              rst;
  logic              c_valid;
  logic [3:0]        c_addr;
  logic [DW-1:0]     c_data;
  logic              c_ready;
  logic [CW-1:0]     cfg_regs;
  logic              cfg_update;
  logic              err_addr;
  logic [3:0]        rd_addr;
  logic [DW-1:0]     rd_data;

  logic              v2;
  logic [3:0]        a2;
  logic [DW-1:0]     d2;
  logic              r2;
  logic [NR2*DW-1:0] regs2;
  logic              upd2;
  logic              err2;
  logic [3:0]        rda2;
  logic [DW-1:0]     rdd2;
`ifdef CONF_WRCNT_EN
  logic [15:0]       wr_count;
  logic [15:0]       wr_count2;
`endif

  always #5 clk = ~clk;

  conf_reg_bank u_dut (
    .clk(clk), .rst(rst), .c_valid(c_valid), .c_addr(c_addr), .c_data(c_data),
    .c_ready(c_ready), .cfg_regs(cfg_regs), .cfg_update(cfg_update), .err_addr(err_addr),
`ifdef CONF_WRCNT_EN
    .wr_count(wr_count),
`endif
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  conf_reg_bank #(.NUM_REGS(NR2)) u_dut12 (
    .clk(clk), .rst(rst), .c_valid(v2), .c_addr(a2), .c_data(d2),
    .c_ready(r2), .cfg_regs(regs2), .cfg_update(upd2), .err_addr(err2),
`ifdef CONF_WRCNT_EN
    .wr_count(wr_count2),
`endif
    .rd_addr(rda2), .rd_data(rdd2)
  );

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] shadow_m [NR];
  logic [DW-1:0] active_m [NR];

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] flat();
    logic [CW-1:0] r;
    for (int i = 0; i < NR; i++) r[i*DW +: DW] = active_m[i];
    return r;
  endfunction

  function automatic logic [DW-1:0] exp_rd(input logic [3:0] a);
    if (int'(a) < NR) return active_m[a];
    return '0;
  endfunction

  task automatic check_rd(input logic [3:0] a);
    rd_addr = a;
    #1;
    chk($sformatf("rd_data[%0d]", a), CW'(rd_data), CW'(exp_rd(a)));
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [3:0] a, input logic [DW-1:0] d);
    int waited = 0;
    c_valid = 1'b1;
    c_addr  = a;
    c_data  = d;
    while (!c_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    chk("send_wait_bound", CW'(waited < 100), CW'(1'b1));
    @(posedge clk);
    #1;
    c_valid = 1'b0;
    if (int'(a) < NR) shadow_m[a] = d;
    else if (a == 4'd15 && d[1]) begin
      for (int i = 0; i < NR; i++) shadow_m[i] = '0;
    end
    @(negedge clk);
    chk("err_addr_after_write", CW'(err_addr), CW'(1'b0));
  endtask

  // Entered at the negedge of cycle N+1 after a commit was accepted in cycle N.
  task automatic run_commit(input string tag);
    for (int k = 1; k <= NR + 2; k++) begin
      chk($sformatf("%s c_ready k=%0d", tag, k), CW'(c_ready), CW'(k == NR + 2));
      chk($sformatf("%s cfg_update k=%0d", tag, k), CW'(cfg_update), CW'(k == NR + 1));
      if (k == NR + 1) begin
        for (int i = 0; i < NR; i++) active_m[i] = shadow_m[i];
        chk($sformatf("%s cfg_regs", tag), cfg_regs, flat());
      end
      if (k < NR + 2) @(negedge clk);
    end
  endtask

  initial begin
    logic [3:0]    ra;
    logic [DW-1:0] rdv, x12;
    logic          upd_seen;
    int            n, k12;

    for (int i = 0; i < NR; i++) begin
      shadow_m[i] = '0;
      active_m[i] = '0;
    end
    rst = 1'b1; c_valid = 1'b0; c_addr = '0; c_data = '0; rd_addr = '0;
    v2 = 1'b0; a2 = '0; d2 = '0; rda2 = '0;
    repeat (3) @(negedge clk);
    chk("reset c_ready", CW'(c_ready), CW'(1'b0));
    chk("reset cfg_update", CW'(cfg_update), CW'(1'b0));
    chk("reset cfg_regs", cfg_regs, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("c_ready after reset", CW'(c_ready), CW'(1'b1));
    chk("c_ready12 after reset", CW'(r2), CW'(1'b1));
    check_rd(4'd0);
    check_rd(4'd15);

    // Shadow write is invisible until a commit.
    send(4'd3, 14'h1ABC);
    chk("no commit cfg_regs", cfg_regs, flat());
    check_rd(4'd3);
    send(4'd15, 14'h0001);
    run_commit("commit1");
    check_rd(4'd3);

    // Random shadow loads followed by commits.
    for (int it = 0; it < 3; it++) begin
      n = $urandom_range(10, 4);
      for (int j = 0; j < n; j++) send(4'($urandom_range(NR - 1, 0)), DW'($urandom));
      chk("pre-commit cfg_regs", cfg_regs, flat());
      send(4'd15, 14'h0001);
      run_commit($sformatf("rand%0d", it));
      for (int j = 0; j < 4; j++) check_rd(4'($urandom_range(15, 0)));
    end

    // Write held during COMMIT must wait for c_ready and land only in shadow.
    shadow_m[5] = 14'h1234;
    send(4'd5, 14'h1234);
    send(4'd15, 14'h0001);
    c_valid = 1'b1; c_addr = 4'd5; c_data = 14'h0055;
    run_commit("hold");
    @(posedge clk);
    #1;
    c_valid = 1'b0;
    shadow_m[5] = 14'h0055;
    @(negedge clk);
    chk("hold active unchanged", cfg_regs, flat());
    check_rd(4'd5);
    send(4'd15, 14'h0001);
    run_commit("hold_commit");
    check_rd(4'd5);

    // Commit address with data 0 is a no-op.
    send(4'd15, 14'h0000);
    chk("noop c_ready", CW'(c_ready), CW'(1'b1));
    @(negedge clk);
    chk("noop cfg_update", CW'(cfg_update), CW'(1'b0));
    chk("noop cfg_regs", cfg_regs, flat());

    // Clear + commit publishes zeros.
    for (int j = 0; j < 6; j++) send(4'($urandom_range(NR - 1, 0)), DW'($urandom) | 14'h0001);
    send(4'd15, 14'h0003);
    run_commit("clear_commit");
    chk("clear_commit zeros", cfg_regs, '0);

    // Reset at COMMIT idx 7 aborts the copy.
    for (int i = 0; i < NR; i++) send(4'(i), DW'($urandom) | 14'h0100);
    send(4'd15, 14'h0001);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NR; i++) begin
      shadow_m[i] = '0;
      active_m[i] = '0;
    end
    chk("midreset cfg_regs", cfg_regs, '0);
    chk("midreset c_ready", CW'(c_ready), CW'(1'b0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("c_ready after midreset", CW'(c_ready), CW'(1'b1));
    upd_seen = 1'b0;
    for (int j = 0; j < 20; j++) begin
      if (cfg_update) upd_seen = 1'b1;
      @(negedge clk);
    end
    chk("no cfg_update after midreset", CW'(upd_seen), CW'(1'b0));
    send(4'd15, 14'h0001);
    run_commit("post_reset");
    chk("post_reset zeros", cfg_regs, '0);

    // NUM_REGS = 12 instance: unmapped address raises err_addr and is dropped.
    x12 = DW'($urandom) | 14'h0001;
    v2 = 1'b1; a2 = 4'd1; d2 = x12;
    @(posedge clk);
    #1;
    a2 = 4'($urandom_range(14, NR2)); d2 = DW'($urandom);
    @(posedge clk);
    #1;
    v2 = 1'b0;
    @(negedge clk);
    chk("err12 pulse", CW'(err2), CW'(1'b1));
    @(negedge clk);
    chk("err12 one cycle", CW'(err2), CW'(1'b0));
    v2 = 1'b1; a2 = 4'd15; d2 = 14'h0001;
    @(posedge clk);
    #1;
    v2 = 1'b0;
    k12 = 0;
    upd_seen = 1'b0;
    while (!upd_seen && k12 < 40) begin
      @(negedge clk);
      k12++;
      upd_seen = upd2;
    end
    chk("upd12 latency", CW'(k12), CW'(NR2 + 1));
    chk("regs12", CW'(regs2), CW'({x12, 14'h0}));
    rda2 = 4'd13;
    #1;
    chk("rd12 unmapped", CW'(rdd2), '0);
    rda2 = 4'd1;
    #1;
    rdv = rdd2;
    chk("rd12 reg1", CW'(rdv), CW'(x12));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
